spi_frame_receiver: RTL and testbench

SPI_FRAME_RECEIVER -- requirements
Module: spi_frame_receiver

---
 rtl/spi_pkg.sv | 15 +
 rtl/sync_bit.sv | 24 ++
 rtl/spi_frame_receiver.sv | 124 ++++++++++++
 tb/tb_spi_frame_receiver.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI frame receiver
package spi_pkg;

  localparam int FRAME_BITS = 24;
  localparam int CNT_W      = 5;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    LATCH   = 2'd2,
    WAIT_CS = 2'd3
  } state_t;

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - single-bit multi-flop synchronizer with selectable reset value
module sync_bit #(
  parameter int   DEPTH     = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= {DEPTH{RESET_VAL}};
    end else begin
      chain <= {chain[DEPTH-2:0], d};
    end
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/spi_frame_receiver.sv
// rtl/spi_frame_receiver.sv - oversampled SPI mode-0 slave capturing 3-byte frames
module spi_frame_receiver
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       sdi,
  input  logic       cs,
  input  logic       clrcmd,
  output logic [7:0] command,
  output logic [7:0] databyte1,
  output logic [7:0] databyte2,
  output logic       spi_done,
  output logic       overrun
);

  logic sck_s, sdi_s, cs_s;
  logic sck_prev;
  logic sck_rise;

  state_t state, state_d;
  logic start, shift_en, latch_en;

  logic [FRAME_BITS-1:0] shift_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  pending;

  sync_bit #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset(reset), .d(sck), .q(sck_s)
  );
  sync_bit #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
    .clk(clk), .reset(reset), .d(sdi), .q(sdi_s)
  );
  sync_bit #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .d(cs), .q(cs_s)
  );

  assign sck_rise = sck_s & ~sck_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sck_prev <= 1'b0;
    end else begin
      state    <= state_d;
      sck_prev <= sck_s;
    end
  end

  always_comb begin
    state_d  = state;
    start    = 1'b0;
    shift_en = 1'b0;
    latch_en = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_s) begin
          state_d = SHIFT;
          start   = 1'b1;
        end
      end
      SHIFT: begin
        // cs release wins over a coincident sck edge: the partial frame is dropped
        if (cs_s) begin
          state_d = IDLE;
        end else if (sck_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) state_d = LATCH;
        end
      end
      LATCH: begin
        latch_en = 1'b1;
        state_d  = WAIT_CS;
      end
      WAIT_CS: begin
        if (cs_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (start) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shift_q <= {shift_q[FRAME_BITS-2:0], sdi_s};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // A new frame takes priority over a coincident acknowledge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      command   <= 8'h00;
      databyte1 <= 8'h00;
      databyte2 <= 8'h00;
      spi_done  <= 1'b0;
      pending   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      spi_done <= latch_en;
      if (latch_en) begin
        command   <= shift_q[23:16];
        databyte1 <= shift_q[15:8];
        databyte2 <= shift_q[7:0];
        pending   <= 1'b1;
        if (pending) overrun <= 1'b1;
      end else if (clrcmd) begin
        command   <= 8'h00;
        databyte1 <= 8'h00;
        databyte2 <= 8'h00;
        pending   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// tb/tb_spi_frame_receiver.sv - randomized scoreboard bench for spi_frame_receiver
module tb_spi_frame_receiver;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sck = 1'b0;
  logic       sdi = 1'b0;
  logic       cs = 1'b1;
  logic       clrcmd = 1'b0;
  logic [7:0] command, databyte1, databyte2;
  logic       spi_done, overrun;

  spi_frame_receiver #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs(cs), .clrcmd(clrcmd),
    .command(command), .databyte1(databyte1), .databyte2(databyte2),
    .spi_done(spi_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int done_seen = 0;
  int done_exp = 0;
  bit pending_m = 1'b0;
  bit ovr_m = 1'b0;

  typedef struct {
    logic [23:0] data;
    bit          ovr;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && spi_done) begin
      done_seen++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spi_done_unexpected: got pulse expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("command", {24'h0, command}, {24'h0, e.data[23:16]});
        chk("databyte1", {24'h0, databyte1}, {24'h0, e.data[15:8]});
        chk("databyte2", {24'h0, databyte2}, {24'h0, e.data[7:0]});
        chk("overrun_at_done", {31'h0, overrun}, {31'h0, e.ovr});
        chk("done_latency", cyc - rise_cyc, SYNC + 2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a window with >=24 bits yields its first 24 bits; overwrite of an unacknowledged frame sets overrun
  task automatic send_frame(input logic [23:0] f, input int nbits, input bit coin_clr, input bit keep_cs);
    if (nbits >= 24) begin
      ovr_m = ovr_m | pending_m;
      pending_m = 1'b1;
      sb.push_back('{data: f, ovr: ovr_m});
      done_exp++;
    end
    cs = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < nbits; i++) begin
      sdi = (i < 24) ? f[23 - i] : 1'($urandom);
      repeat (3) tick();
      sck = 1'b1;
      if (i == 23) rise_cyc = cyc;
      for (int k = 0; k < 3; k++) begin
        tick();
        if (coin_clr && i == 23 && k == 2) clrcmd = 1'b1;
      end
      sck = 1'b0;
      tick();
      clrcmd = 1'b0;
    end
    if (!keep_cs) begin
      repeat (3) tick();
      cs = 1'b1;
      repeat (6) tick();
    end
  endtask

  task automatic clear_and_check();
    clrcmd = 1'b1;
    tick();
    clrcmd = 1'b0;
    pending_m = 1'b0;
    chk("clr_command", {24'h0, command}, 32'h0);
    chk("clr_databyte1", {24'h0, databyte1}, 32'h0);
    chk("clr_databyte2", {24'h0, databyte2}, 32'h0);
    repeat (2) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sck = 1'b0;
    cs = 1'b1;
    clrcmd = 1'b0;
    repeat (2) tick();
    chk("rst_command", {24'h0, command}, 32'h0);
    chk("rst_overrun", {31'h0, overrun}, 32'h0);
    pending_m = 1'b0;
    ovr_m = 1'b0;
    reset = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    logic [23:0] f;
    int nb;

    repeat (3) tick();
    chk("reset_command", {24'h0, command}, 32'h0);
    chk("reset_databyte1", {24'h0, databyte1}, 32'h0);
    chk("reset_databyte2", {24'h0, databyte2}, 32'h0);
    chk("reset_spi_done", {31'h0, spi_done}, 32'h0);
    chk("reset_overrun", {31'h0, overrun}, 32'h0);
    reset = 1'b1;
    repeat (4) tick();

    send_frame(24'hC3051A, 24, 1'b0, 1'b0);
    chk("first_frame_no_overrun", {31'h0, overrun}, 32'h0);
    send_frame(24'($urandom), 24, 1'b0, 1'b0);
    chk("second_frame_overrun", {31'h0, overrun}, {31'h0, ovr_m});
    do_reset();

    send_frame(24'($urandom), 13, 1'b0, 1'b0);
    send_frame(24'h80002A, 24, 1'b0, 1'b0);
    clear_and_check();

    send_frame(24'($urandom), 30, 1'b0, 1'b0);
    clear_and_check();

    send_frame(24'($urandom), 24, 1'b0, 1'b0);
    clear_and_check();
    f = 24'($urandom);
    send_frame(f, 24, 1'b1, 1'b0);
    chk("coin_clr_keeps_command", {24'h0, command}, {24'h0, f[23:16]});
    chk("coin_clr_keeps_databyte2", {24'h0, databyte2}, {24'h0, f[7:0]});
    chk("coin_clr_no_overrun", {31'h0, overrun}, 32'h0);
    send_frame(24'($urandom), 24, 1'b0, 1'b0);
    chk("coin_clr_then_overrun", {31'h0, overrun}, 32'h1);

    do_reset();
    send_frame(24'($urandom), 10, 1'b0, 1'b1);
    do_reset();
    send_frame(24'hC10203, 24, 1'b0, 1'b0);
    chk("after_rst_command", {24'h0, command}, 32'hC1);
    chk("after_rst_databyte1", {24'h0, databyte1}, 32'h02);
    chk("after_rst_databyte2", {24'h0, databyte2}, 32'h03);
    chk("after_rst_overrun", {31'h0, overrun}, 32'h0);

    for (int n = 0; n < 20; n++) begin
      f = 24'($urandom);
      if ($urandom_range(3, 0) != 0) nb = $urandom_range(30, 24);
      else nb = $urandom_range(23, 1);
      send_frame(f, nb, 1'b0, 1'b0);
      if ($urandom_range(1, 0) == 1) clear_and_check();
    end

    repeat (10) tick();
    chk("done_count", done_seen, done_exp);
    chk("scoreboard_empty", sb.size(), 0);
    chk("overrun_final", {31'h0, overrun}, {31'h0, ovr_m});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
